fifo_vc: RTL and testbench

Synchronous virtual-channel FIFO that sits directly downstream of the 4-output arbiter. One instance per output channel: the arbiter's `pushN` drives `push`, and this block returns `almost_full` and `empty` so the arbiter can throttle. Programmable almost-full/almost-empty thresholds are loaded while the system control FSM is in its init state.

---
 rtl/fifo_vc.sv | 85 ++++++++
 tb/tb_fifo_vc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_vc.sv
// Virtual-channel FIFO with registered read data and programmable almost-full/empty thresholds.
// Optional sticky overflow/underflow flag enabled by defining FIFO_ERR_EN.
module fifo_vc #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  input  logic              th_load,
  input  logic [ADDR_W:0]   th_af,
  input  logic [ADDR_W:0]   th_ae,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);
  localparam int            DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wp, r_rp;
  logic [ADDR_W:0]   r_count, r_af, r_ae;
  logic [DATA_W-1:0] r_dout;

  logic            w_push_ok, w_pop_ok;
  logic [ADDR_W:0] w_af_cl, w_ae_cl;

  assign empty        = (r_count == '0);
  assign full         = (r_count == L_DEPTH);
  assign almost_full  = (r_count >= r_af);
  assign almost_empty = (r_count <= r_ae);
  assign count        = r_count;
  assign data_out     = r_dout;

  // A pop frees a slot in the same cycle, so push is accepted when full if paired with pop.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  assign w_af_cl = (th_af > L_DEPTH) ? L_DEPTH : th_af;
  assign w_ae_cl = (th_ae > L_DEPTH) ? L_DEPTH : th_ae;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_af    <= L_DEPTH - 1'b1;
      r_ae    <= (ADDR_W+1)'(1);
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok) begin
        r_dout <= r_mem[r_rp];
        r_rp   <= r_rp + 1'b1;
      end
      r_count <= r_count + (ADDR_W+1)'(w_push_ok) - (ADDR_W+1)'(w_pop_ok);
      if (th_load) begin
        r_af <= w_af_cl;
        r_ae <= w_ae_cl;
      end
    end
  end

`ifdef FIFO_ERR_EN
  logic r_error;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        r_error <= 1'b0;
    else if ((push && full && !pop) || (pop && empty)) r_error <= 1'b1;
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_vc.sv
// Self-checking bench for fifo_vc: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_fifo_vc;
  localparam int DW = 6;
  localparam int AW = 2;
  localparam int DEPTH = 4;
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, push, pop, th_load;
  logic [DW-1:0] data_in, data_out;
  logic [AW:0]   th_af, th_ae, count;
  logic          empty, full, almost_full, almost_empty, error;

  fifo_vc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .th_load(th_load), .th_af(th_af), .th_ae(th_ae),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of stored words plus threshold/flag state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  int            m_af, m_ae;
  bit            m_err;

  typedef struct {
    bit          p;
    logic [DW-1:0] d;
    bit          o;
    bit          tl;
    logic [AW:0] fa, ea;
    int          ecnt;
    logic [DW-1:0] edout;
    bit          ee, ef, eaf, eae;
  } vec_t;

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_af = DEPTH - 1; m_ae = 1; m_err = 1'b0;
  endtask

  task automatic model_step(bit p, logic [DW-1:0] d, bit o, bit tl, int fa, int ea);
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (ERR_EN && ((p && was_full && !o) || (o && was_empty))) m_err = 1'b1;
    if (o && !was_empty) m_dout = q.pop_front();
    if (p && (!was_full || o)) q.push_back(d);
    if (tl) begin
      m_af = (fa > DEPTH) ? DEPTH : fa;
      m_ae = (ea > DEPTH) ? DEPTH : ea;
    end
  endtask

  task automatic cyc(bit p, logic [DW-1:0] d, bit o, bit tl, logic [AW:0] fa, logic [AW:0] ea);
    push = p; data_in = d; pop = o; th_load = tl; th_af = fa; th_ae = ea;
    @(posedge clk);
    model_step(p, d, o, tl, int'(fa), int'(ea));
    #1;
  endtask

  task automatic check_model(string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, int'(count), n);
    chk({tag, ".dout"}, int'(data_out), int'(m_dout));
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".full"}, int'(full), int'(n == DEPTH));
    chk({tag, ".afull"}, int'(almost_full), int'(n >= m_af));
    chk({tag, ".aempty"}, int'(almost_empty), int'(n <= m_ae));
    chk({tag, ".error"}, int'(error), int'(m_err));
  endtask

  vec_t tbl[17];

  initial begin
    reset = 1'b1; push = 0; pop = 0; th_load = 0; data_in = '0; th_af = '0; th_ae = '0;
    model_reset();
    #3;
    chk("rst.count", int'(count), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.full", int'(full), 0);
    chk("rst.afull", int'(almost_full), 0);
    chk("rst.aempty", int'(almost_empty), 1);
    chk("rst.dout", int'(data_out), 0);
    chk("rst.error", int'(error), 0);
    @(negedge clk); reset = 1'b0;

    //            p  d      o  tl fa ea  cnt dout   e  f  af ae
    tbl[0]  = '{1, 6'h11, 0, 0, 0, 0, 1, 6'h00, 0, 0, 0, 1};
    tbl[1]  = '{1, 6'h22, 0, 0, 0, 0, 2, 6'h00, 0, 0, 0, 0};
    tbl[2]  = '{1, 6'h33, 0, 0, 0, 0, 3, 6'h00, 0, 0, 1, 0};
    tbl[3]  = '{1, 6'h04, 0, 0, 0, 0, 4, 6'h00, 0, 1, 1, 0};
    tbl[4]  = '{1, 6'h05, 0, 0, 0, 0, 4, 6'h00, 0, 1, 1, 0}; // overflow dropped
    tbl[5]  = '{1, 6'h3F, 1, 0, 0, 0, 4, 6'h11, 0, 1, 1, 0}; // push+pop full
    tbl[6]  = '{0, 6'h00, 1, 0, 0, 0, 3, 6'h22, 0, 0, 1, 0};
    tbl[7]  = '{0, 6'h00, 1, 0, 0, 0, 2, 6'h33, 0, 0, 0, 0};
    tbl[8]  = '{0, 6'h00, 1, 0, 0, 0, 1, 6'h04, 0, 0, 0, 1};
    tbl[9]  = '{0, 6'h00, 1, 0, 0, 0, 0, 6'h3F, 1, 0, 0, 1};
    tbl[10] = '{0, 6'h00, 1, 0, 0, 0, 0, 6'h3F, 1, 0, 0, 1}; // underflow ignored
    tbl[11] = '{1, 6'h2A, 1, 0, 0, 0, 1, 6'h3F, 0, 0, 0, 1}; // push+pop empty
    tbl[12] = '{0, 6'h00, 0, 1, 2, 0, 1, 6'h3F, 0, 0, 0, 0};
    tbl[13] = '{1, 6'h15, 0, 0, 0, 0, 2, 6'h3F, 0, 0, 1, 0};
    tbl[14] = '{1, 6'h16, 0, 1, 7, 0, 3, 6'h3F, 0, 0, 0, 0}; // af clamps to 4
    tbl[15] = '{1, 6'h17, 0, 0, 0, 0, 4, 6'h3F, 0, 1, 1, 0};
    tbl[16] = '{0, 6'h00, 1, 0, 0, 0, 3, 6'h2A, 0, 0, 0, 0};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].p, tbl[i].d, tbl[i].o, tbl[i].tl, tbl[i].fa, tbl[i].ea);
      chk($sformatf("v%0d.count", i), int'(count), tbl[i].ecnt);
      chk($sformatf("v%0d.dout", i), int'(data_out), int'(tbl[i].edout));
      chk($sformatf("v%0d.empty", i), int'(empty), int'(tbl[i].ee));
      chk($sformatf("v%0d.full", i), int'(full), int'(tbl[i].ef));
      chk($sformatf("v%0d.afull", i), int'(almost_full), int'(tbl[i].eaf));
      chk($sformatf("v%0d.aempty", i), int'(almost_empty), int'(tbl[i].eae));
      chk($sformatf("v%0d.error", i), int'(error), int'(ERR_EN && i >= 4));
    end

    // Asynchronous reset mid-stream with count=3, between clock edges.
    push = 0; pop = 0; th_load = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("mrst.count", int'(count), 0);
    chk("mrst.empty", int'(empty), 1);
    chk("mrst.aempty", int'(almost_empty), 1);
    chk("mrst.afull", int'(almost_full), 0);
    chk("mrst.dout", int'(data_out), 0);
    chk("mrst.error", int'(error), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Default thresholds visible through flags: af at 3, ae at 1.
    for (int i = 0; i < 3; i++) cyc(1, 6'(i + 1), 0, 0, 0, 0);
    chk("dth.afull3", int'(almost_full), 1);
    chk("dth.aempty3", int'(almost_empty), 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0, 0);
    check_model("dth");

    // Wrap-around: occupancy 2, ten push/pop pairs.
    cyc(1, 6'h01, 0, 0, 0, 0);
    cyc(1, 6'h02, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, 6'(10 + k), 1, 0, 0, 0);
      chk($sformatf("wrap%0d.dout", k), int'(data_out), (k == 0) ? 1 : (k == 1) ? 2 : 10 + k - 2);
      chk($sformatf("wrap%0d.count", k), int'(count), 2);
    end
    check_model("wrap");

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
